// File: rtl/shift_reg.sv
// Serial-in/serial-out shift register with synchronous parallel load.
// Load wins over shift; the asynchronous active-low reset clears everything.
module shift_reg #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         res_n,
  input  logic         en,
  input  logic         din,
  input  logic         load_en,
  input  logic [N-1:0] load,
  output logic         dout
);

  logic [N-1:0] q_q;
  logic [N-1:0] q_d;
  logic [N-1:0] shifted;

  // A one-bit register has no lower bits to carry forward.
  if (N == 1) begin : g_single
    assign shifted = din;
  end else begin : g_multi
    assign shifted = {q_q[N-2:0], din};
  end

  always_comb begin
    q_d = q_q;
    if (load_en) begin
      q_d = load;
    end else if (en) begin
      q_d = shifted;
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  // Straight from the flop, so there is no combinational input-to-output path.
  assign dout = q_q[N-1];

endmodule

// File: tb/tb_shift_reg.sv
// Self-checking bench for shift_reg (N=4): table-driven vectors via a scoreboard queue,
// plus hand-written sequences for asynchronous reset corner cases.
module tb_shift_reg;

  localparam int unsigned N = 4;

  typedef struct {
    logic         res_n;
    logic         en;
    logic         din;
    logic         load_en;
    logic [N-1:0] load;
    logic         exp_dout;
    string        name;
  } vec_t;

  logic         clk = 1'b0;
  logic         res_n;
  logic         en;
  logic         din;
  logic         load_en;
  logic [N-1:0] load;
  logic         dout;

  int checks = 0;
  int errors = 0;
  logic exp_q[$];
  vec_t vecs[$];

  shift_reg #(.N(N)) dut (
    .clk     (clk),
    .res_n   (res_n),
    .en      (en),
    .din     (din),
    .load_en (load_en),
    .load    (load),
    .dout    (dout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic r, input logic e, input logic d, input logic le,
                              input logic [N-1:0] ld, input logic ex, input string nm);
    vec_t v;
    v.res_n = r; v.en = e; v.din = d; v.load_en = le; v.load = ld; v.exp_dout = ex;
    v.name = nm;
    return v;
  endfunction

  task automatic check(input string name, input logic expd);
    checks++;
    if (dout !== expd) begin
      errors++;
      $display("FAIL %s: dout=%b expected %b at t=%0t", name, dout, expd, $time);
    end
  endtask

  // Drive one vector between edges, then compare dout just after the next rising edge.
  task automatic step(input vec_t v);
    @(negedge clk);
    res_n = v.res_n; en = v.en; din = v.din; load_en = v.load_en; load = v.load;
    exp_q.push_back(v.exp_dout);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty", v.name);
    end else begin
      check(v.name, exp_q.pop_front());
    end
  endtask

  initial begin
    res_n = 1'b0; en = 1'b0; din = 1'b0; load_en = 1'b0; load = '0;

    // Reset with no clock edge yet.
    #2;
    check("reset_no_edge", 1'b0);

    // Single pulse, with a two-cycle stall in the middle.
    vecs.push_back(mk(1, 1, 1, 0, 4'h0, 0, "pulse_e1"));
    vecs.push_back(mk(1, 1, 0, 0, 4'h0, 0, "pulse_e2"));
    vecs.push_back(mk(1, 0, 1, 0, 4'h0, 0, "pulse_stall1"));
    vecs.push_back(mk(1, 0, 1, 0, 4'h0, 0, "pulse_stall2"));
    vecs.push_back(mk(1, 1, 0, 0, 4'h0, 0, "pulse_e3"));
    vecs.push_back(mk(1, 1, 0, 0, 4'h0, 1, "pulse_e4"));
    vecs.push_back(mk(1, 1, 0, 0, 4'h0, 0, "pulse_e5"));
    vecs.push_back(mk(1, 1, 0, 0, 4'h0, 0, "pulse_e6"));
    // Two-bit burst.
    vecs.push_back(mk(1, 1, 1, 0, 4'h0, 0, "burst_e1"));
    vecs.push_back(mk(1, 1, 1, 0, 4'h0, 0, "burst_e2"));
    vecs.push_back(mk(1, 1, 0, 0, 4'h0, 0, "burst_e3"));
    vecs.push_back(mk(1, 1, 0, 0, 4'h0, 1, "burst_e4"));
    vecs.push_back(mk(1, 1, 0, 0, 4'h0, 1, "burst_e5"));
    vecs.push_back(mk(1, 1, 0, 0, 4'h0, 0, "burst_e6"));
    vecs.push_back(mk(1, 1, 0, 0, 4'h0, 0, "burst_e7"));
    vecs.push_back(mk(1, 1, 0, 0, 4'h0, 0, "burst_e8"));
    // Alternating 1,0,1,0.
    vecs.push_back(mk(1, 1, 1, 0, 4'h0, 0, "alt_e1"));
    vecs.push_back(mk(1, 1, 0, 0, 4'h0, 0, "alt_e2"));
    vecs.push_back(mk(1, 1, 1, 0, 4'h0, 0, "alt_e3"));
    vecs.push_back(mk(1, 1, 0, 0, 4'h0, 1, "alt_e4"));
    vecs.push_back(mk(1, 1, 0, 0, 4'h0, 0, "alt_e5"));
    vecs.push_back(mk(1, 1, 0, 0, 4'h0, 1, "alt_e6"));
    vecs.push_back(mk(1, 1, 0, 0, 4'h0, 0, "alt_e7"));
    // Load 1011 with en=0, then shift zeros with a stall inserted.
    vecs.push_back(mk(1, 0, 0, 1, 4'b1011, 1, "load_edge"));
    vecs.push_back(mk(1, 0, 1, 0, 4'b0000, 1, "load_hold"));
    vecs.push_back(mk(1, 1, 0, 0, 4'b0000, 0, "load_s1"));
    vecs.push_back(mk(1, 0, 1, 0, 4'b0000, 0, "load_stall"));
    vecs.push_back(mk(1, 1, 0, 0, 4'b0000, 1, "load_s2"));
    vecs.push_back(mk(1, 1, 0, 0, 4'b0000, 1, "load_s3"));
    vecs.push_back(mk(1, 1, 0, 0, 4'b0000, 0, "load_s4"));
    // Load beats shift: en=1, din=1 ignored; q becomes 0101.
    vecs.push_back(mk(1, 1, 1, 1, 4'b0101, 0, "prio_load"));
    vecs.push_back(mk(1, 1, 0, 0, 4'b0000, 1, "prio_s1"));
    vecs.push_back(mk(1, 1, 0, 0, 4'b0000, 0, "prio_s2"));
    vecs.push_back(mk(1, 1, 0, 0, 4'b0000, 1, "prio_s3"));
    vecs.push_back(mk(1, 1, 0, 0, 4'b0000, 0, "prio_s4"));

    @(negedge clk);
    res_n = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i]);
    end

    // Mid-cycle asynchronous reset while a pattern of ones is in flight.
    step(mk(1, 0, 0, 1, 4'b1111, 1, "arst_preload"));
    #3;
    res_n = 1'b0;
    #1;
    check("arst_immediate", 1'b0);
    // Held in reset: a load edge must not take effect.
    step(mk(0, 1, 1, 1, 4'b1111, 0, "arst_load_edge"));
    step(mk(0, 1, 1, 0, 4'b0000, 0, "arst_shift_edge"));
    // The discarded ones must never come back.
    for (int i = 0; i < 4; i++) begin
      step(mk(1, 1, 0, 0, 4'b0000, 0, $sformatf("arst_gone_%0d", i)));
    end

    // First edge after release performs a load.
    @(negedge clk);
    res_n = 1'b0;
    #2;
    check("rst_pulse2", 1'b0);
    step(mk(1, 0, 0, 1, 4'b1000, 1, "release_load"));
    step(mk(1, 1, 0, 0, 4'b0000, 0, "release_s1"));

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_reg.md
SHIFT_REG -- requirements
Module: shift_reg

Interface
REQ-001 The block SHALL have one parameter: N, default 4, register length in bits (legal range N >= 1).
REQ-002 The block SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 The block SHALL have port: res_n  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port: en  input  1  shift enable.
REQ-005 The block SHALL have port: din  input  1  serial data in.
REQ-006 The block SHALL have port: load_en  input  1  parallel-load enable.
REQ-007 The block SHALL have port: load  input  N  parallel-load data.
REQ-008 The block SHALL have port: dout  output  1  serial data out.
REQ-009 The block SHALL use one clock and an asynchronous, active-low reset, named clk and res_n.

Function
REQ-010 The block SHALL hold an internal N-bit register q[N-1:0].
REQ-011 dout SHALL equal q[N-1], driven directly from the flop with no combinational path from any input.
REQ-012 With res_n=1, load_en=0 and en=1, each rising edge SHALL set q <= {q[N-2:0], din}, i.e. din enters the LSB and data moves toward the MSB; for N=1, q <= din.
REQ-013 With res_n=1, load_en=0 and en=0, q SHALL hold its value.
REQ-014 With res_n=1 and load_en=1, each rising edge SHALL set q <= load, regardless of en.
REQ-015 Load SHALL take priority over shift; din SHALL be ignored on a load edge.
REQ-016 Latency: a din value sampled at an enabled edge k SHALL appear on dout after edge k+N-1, i.e. N enabled edges after it was presented, and SHALL persist for one enabled cycle.
REQ-017 Cycles with en=0 SHALL stall the pipeline without losing or duplicating bits.
REQ-018 After a load, dout SHALL show load[N-1] immediately after the load edge.
REQ-019 Subsequent enabled edges SHALL present load[N-2], ..., load[0] on dout, followed by the shifted-in din bits.
REQ-020 The block SHALL NOT produce X on dout once reset has been applied, provided inputs are known.

Reset
REQ-021 While res_n=0, q SHALL be all zeros and dout SHALL be 0, asynchronously, independent of clk, en, load_en and din.
REQ-022 Reset asserted mid-shift or on a load edge SHALL override the operation; all in-flight data SHALL be discarded.
REQ-023 On release of res_n, the first rising edge at which res_n=1 SHALL perform normal shift, hold or load per REQ-012..REQ-014.

Verification (N=4)
REQ-024 Reset check: pulse res_n=0 for one cycle between edges -> dout=0 immediately, with no clock edge required.
REQ-025 Single-pulse check: en=1, din=1 for one cycle then 0 -> dout=1 for exactly one cycle, 4 edges after din was presented, otherwise 0.
REQ-026 Two-bit burst check: din=1 for two cycles then 0 -> dout=1 for exactly two consecutive cycles, delayed 4 cycles.
REQ-027 Alternating-pattern check: din=1,0,1,0 -> dout=1,0,1,0 after 4 cycles, then 0.
REQ-028 Load-and-stall check: load_en=1, load=4'b1011, en=0 for one edge -> dout=1; then en=1, load_en=0, din=0 -> dout=0,1,1,0; inserting en=0 cycles holds dout unchanged.
REQ-029 Priority and mid-operation reset check: load_en=1 with en=1 and din=1 -> q==load; res_n=0 during shifting -> dout=0 at once and the prior pattern never reappears.
